// File: rtl/banked_glb_pkg.sv
// Shared helpers for the banked global buffer: lane offsets and bank geometry.
package glb_pkg;

  typedef int unsigned bank_idx_t;

  function automatic int unsigned lane_slice(input bank_idx_t i, input int unsigned dw);
    return i * dw;
  endfunction

  function automatic int unsigned bank_bits(input int unsigned num_banks);
    return $clog2(num_banks);
  endfunction

  function automatic int unsigned bank_depth(input int unsigned depth, input int unsigned num_banks);
    return depth / num_banks;
  endfunction

endpackage

// File: rtl/banked_glb_bank.sv
// One read-first dual-port bank with registered reads on both ports.
module glb_bank #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ROW_W      = 8,
  parameter int unsigned BANK_DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_a,
  input  logic                  re_a,
  input  logic [ROW_W-1:0]      row_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic                  we_b,
  input  logic                  re_b,
  input  logic [ROW_W-1:0]      row_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];

  // Port A is written last so it wins if both ports ever target one row.
  always_ff @(posedge clk) begin
    if (we_b) mem[row_b] <= wdata_b;
    if (we_a) mem[row_a] <= wdata_a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (re_a) rdata_a <= mem[row_a];
      if (re_b) rdata_b <= mem[row_b];
    end
  end

endmodule

// File: rtl/banked_glb.sv
// Banked dual-port global buffer: wide masked row port A, single-element port B,
// optional output register and write/write collision counting.
module banked_glb
  import glb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned ADDR       = $clog2(DEPTH)
) (
  input  logic                            core_clk,
  input  logic                            core_rst_n,
  input  logic                            we_a,
  input  logic                            re_a,
  input  logic [ADDR-1:0]                 addr_a,
  input  logic [NUM_BANKS-1:0]            wmask_a,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] wdata_a,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] rdata_a,
  output logic                            rvalid_a,
  input  logic                            we_b,
  input  logic                            re_b,
  input  logic [ADDR-1:0]                 addr_b,
  input  logic [DATA_WIDTH-1:0]           wdata_b,
  output logic [DATA_WIDTH-1:0]           rdata_b,
  output logic                            rvalid_b,
  output logic                            collision,
  output logic [CNT_WIDTH-1:0]            coll_cnt,
  input  logic                            coll_clr
);

  localparam int unsigned BB         = bank_bits(NUM_BANKS);
  localparam int unsigned BANK_DEPTH = bank_depth(DEPTH, NUM_BANKS);
  localparam int unsigned ROW_W      = ADDR - BB;

  if ((DEPTH % NUM_BANKS) != 0 || NUM_BANKS < 2 || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_bad_cfg
    $fatal(1, "banked_glb: NUM_BANKS must be a power of 2 (>=2) dividing DEPTH");
  end

  logic [ROW_W-1:0] row_a, row_b;
  logic [BB-1:0]    bank_b;
  logic             rd_a, rd_b, coll;

  assign row_a  = addr_a[ADDR-1:BB];
  assign row_b  = addr_b[ADDR-1:BB];
  assign bank_b = addr_b[BB-1:0];
  assign rd_a   = re_a & ~we_a;
  assign rd_b   = re_b & ~we_b;
  assign coll   = we_a & wmask_a[bank_b] & we_b & (row_a == row_b);

  logic [NUM_BANKS*DATA_WIDTH-1:0] row_rd_a;
  logic [DATA_WIDTH-1:0]           bank_rd_b [NUM_BANKS];

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    logic sel_b;
    assign sel_b = (bank_b == BB'(k));

    glb_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ROW_W      (ROW_W),
      .BANK_DEPTH (BANK_DEPTH)
    ) u_bank (
      .clk     (core_clk),
      .rst_n   (core_rst_n),
      .we_a    (we_a & wmask_a[k]),
      .re_a    (rd_a),
      .row_a   (row_a),
      .wdata_a (wdata_a[lane_slice(k, DATA_WIDTH) +: DATA_WIDTH]),
      .rdata_a (row_rd_a[lane_slice(k, DATA_WIDTH) +: DATA_WIDTH]),
      .we_b    (we_b & sel_b & ~coll),
      .re_b    (rd_b & sel_b),
      .row_b   (row_b),
      .wdata_b (wdata_b),
      .rdata_b (bank_rd_b[k])
    );
  end

  logic          rv_a1, rv_b1;
  logic [BB-1:0] bsel1;

  // bsel1 only moves on an accepted read so the muxed port-B data holds between reads.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      rv_a1     <= 1'b0;
      rv_b1     <= 1'b0;
      bsel1     <= '0;
      collision <= 1'b0;
      coll_cnt  <= '0;
    end else begin
      rv_a1     <= rd_a;
      rv_b1     <= rd_b;
      if (rd_b) bsel1 <= bank_b;
      collision <= coll;
      if (coll_clr)
        coll_cnt <= '0;
      else if (coll && coll_cnt != '1)
        coll_cnt <= coll_cnt + CNT_WIDTH'(1);
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
        rdata_a  <= '0;
        rdata_b  <= '0;
        rvalid_a <= 1'b0;
        rvalid_b <= 1'b0;
      end else begin
        rvalid_a <= rv_a1;
        rvalid_b <= rv_b1;
        if (rv_a1) rdata_a <= row_rd_a;
        if (rv_b1) rdata_b <= bank_rd_b[bsel1];
      end
    end
  end else begin : g_direct
    assign rdata_a  = row_rd_a;
    assign rdata_b  = bank_rd_b[bsel1];
    assign rvalid_a = rv_a1;
    assign rvalid_b = rv_b1;
  end

endmodule

// File: doc/banked_glb.md
Name: banked_glb

Overview:
- Parametrised dual-port global buffer, the successor to the fixed 4-bank ifmap/psum GLBs.
- Port A is a wide row port of NUM_BANKS x DATA_WIDTH, used by the DRAM-side FIFO. Port B is a single-element port, used by the PE-array side.
- Adds a per-lane write mask on port A, read-valid strobes, an optional output register stage, and cross-port collision detection with a saturating collision counter.

Parameters:
- DATA_WIDTH, 16, element width in bits.
- NUM_BANKS, 4, number of banks and elements per port-A row. Power of 2, at least 2.
- DEPTH, 1024, total elements. Must be a multiple of NUM_BANKS.
- OUT_REG, 0, value 1 adds one output register stage on both read paths.
- CNT_WIDTH, 16, width of the collision counter.
- ADDR, $clog2(DEPTH), element address width.

Ports:
- core_clk  in  1  clock
- core_rst_n  in  1  asynchronous active-low reset
- we_a  in  1  port A row write
- re_a  in  1  port A row read
- addr_a  in  ADDR  element address. Bits [BB-1:0] are ignored, BB = $clog2(NUM_BANKS).
- wmask_a  in  NUM_BANKS  per-lane write enable for port A
- wdata_a  in  NUM_BANKS*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- rdata_a  out  NUM_BANKS*DATA_WIDTH  row read data
- rvalid_a  out  1  rdata_a valid
- we_b  in  1  port B element write
- re_b  in  1  port B element read
- addr_b  in  ADDR  element address; bank = addr_b[BB-1:0], row = addr_b[ADDR-1:BB]
- wdata_b  in  DATA_WIDTH  port B write data
- rdata_b  out  DATA_WIDTH  port B read data
- rvalid_b  out  1  rdata_b valid
- collision  out  1  one-cycle pulse on a write/write collision
- coll_cnt  out  CNT_WIDTH  saturating collision count
- coll_clr  in  1  synchronous clear of coll_cnt

Behaviour:
- Reset values (asynchronous, core_rst_n low): rdata_a=0, rdata_b=0, rvalid_a=0, rvalid_b=0, collision=0, coll_cnt=0, registered bank select=0. Memory contents are not reset.
- Reset mid-operation: in-flight reads are discarded and no rvalid fires after reset is released.
- Bank storage: each bank holds DEPTH/NUM_BANKS words, is synchronous and read-first.
- Port A:
  - Write: we_a writes lane i to bank i at row addr_a[ADDR-1:BB] only where wmask_a[i]=1.
  - Read: re_a reads all banks at that row.
- Port B: only the bank selected by addr_b[BB-1:0] is enabled.
- Same-port precedence: if we and re are both high on one port, the write is performed, the read is suppressed and no rvalid is issued.
- Latency: L = 1 + OUT_REG.
  - A read accepted in cycle t drives rdata and rvalid in cycle t+L.
  - rvalid is high for exactly one cycle per accepted read.
  - Back-to-back reads sustain one result per cycle.
- Port B read mux: the bank select travels down the same L-stage pipeline as rvalid_b, so consecutive reads to different banks mux correctly.
- Data hold: rdata holds its last value when rvalid is low.
- Write/write collision:
  - Condition: we_a and wmask_a[bank_b] and we_b in the same cycle with equal rows.
  - Port A data is written; the port B write is dropped.
  - collision pulses high in the next cycle.
  - coll_cnt increments and saturates at all-ones.
- Read/write collision (one port reads while the other writes the same cell): the read returns the old data (read-first). This is not counted.
- coll_clr: zeroes coll_cnt next cycle and takes priority over a same-cycle increment.
- Elaboration checks: fatal error if DEPTH % NUM_BANKS != 0 or NUM_BANKS is not a power of 2.

Decomposition:
- Package glb_pkg:
  - localparams BB and BANK_DEPTH.
  - Function lane_slice(i) giving the bit offset of lane i.
  - Typedef bank_idx_t.
- Sub-module glb_bank: one read-first dual-port bank with per-port we/re and a registered read, instantiated NUM_BANKS times in a generate loop.
- Top level holds: the mask/select decode, the collision logic, the rvalid/bank-select pipeline, the OUT_REG stage and the counter.

Test Plan:
Bench configuration: DATA_WIDTH=16, NUM_BANKS=4, DEPTH=64.
- Row write then element read (OUT_REG=0): write port A, addr_a=8, wdata_a=0x4444_3333_2222_1111, mask=4'hF. Then read port B at addr_b=8,9,10,11 back-to-back. Required: rdata_b = 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles, rvalid_b high for 4 cycles, each one cycle after its request.
- Masked write: write port A, addr_a=8, mask=4'b0101, wdata=0xFFFF… Then read port A at row 8. Required: rdata_a = 0x4444_FFFF_2222_FFFF.
- Write/write collision: same cycle, we_a at addr_a=12 with mask=4'hF and data lanes 0xAAAA, plus we_b at addr_b=13 with 0x5555. Required: collision pulses once, coll_cnt=1, and a later read of addr 13 returns 0xAAAA. Repeat with mask=4'b1101: required no collision and addr 13 returns 0x5555.
- Read-first: port A reads row 12 in the same cycle as port B writes addr 12 = 0x7777. Required: lane 0 of rdata_a returns the old value. The next read returns 0x7777.
- OUT_REG=1 pipeline: re_b pulses at addr 0, then 1, 2, 3. Required: rvalid_b rises 2 cycles after the first request, with correct data ordering. Assert core_rst_n low mid-stream: required rvalid_b=0 immediately and stays 0 after reset is released.
- Counter: force 2^CNT_WIDTH+3 collisions. Required: coll_cnt stays saturated at 0xFFFF. Assert coll_clr in the same cycle as a collision: required coll_cnt=0 next cycle.
